// File: rtl/bcd_alu_pkg.sv
// Shared constants for the packed-BCD arithmetic unit: opcodes and digit sizing.
package bcd_alu_pkg;

   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_RSV  = 2'b11;

   localparam int BCD_DIGIT_W        = 4;
   localparam int DEFAULT_NUM_DIGITS = 4;

endpackage

// File: rtl/bcd_alu_digit_adder.sv
// Single BCD digit adder: binary sum with carry in, +6 correction above 9.
module bcd_digit_adder
   import bcd_alu_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] a,
   input  logic [BCD_DIGIT_W-1:0] b,
   input  logic                   cin,
   output logic [BCD_DIGIT_W-1:0] sum,
   output logic                   cout
);

   logic [BCD_DIGIT_W:0] bin_sum;
   logic [BCD_DIGIT_W:0] adj_sum;

   assign bin_sum = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
   assign adj_sum = bin_sum + 5'd6;

   always_comb begin
      sum  = bin_sum[BCD_DIGIT_W-1:0];
      cout = 1'b0;
      if (bin_sum > 5'd9) begin
         sum  = adj_sum[BCD_DIGIT_W-1:0];
         cout = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_alu.sv
// Registered packed-BCD add/subtract unit with sign/overflow flag.
// Optional input digit validation is enabled by defining BCD_ALU_DIGIT_CHECK_EN.
module bcd_alu
   import bcd_alu_pkg::*;
#(
   parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
)(
   input  logic                              clk,
   input  logic                              clear,
   input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] bcd1,
   input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] bcd2,
   input  logic [1:0]                        op_selected,
   output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] bcd_out,
   output logic                              special_signal
);

   localparam int W = BCD_DIGIT_W*NUM_DIGITS;

   logic            is_add;
   logic            is_sub;
   logic [NUM_DIGITS:0] c1;
   logic [NUM_DIGITS:0] c2;
   logic [W-1:0]    b_sel;
   logic [W-1:0]    raw;
   logic [W-1:0]    raw_comp;
   logic [W-1:0]    mag;
   logic            cmp_carry_unused;
   logic [W-1:0]    res_next;
   logic            flag_next;
   logic [W-1:0]    bcd_out_reg;
   logic            flag_reg;

   assign is_add = (op_selected == OP_ADD);
   assign is_sub = (op_selected == OP_SUB);

   // Subtraction is A + 9's(B) + 1; the carry out of the top digit means A >= B.
   assign c1[0] = is_sub;
   assign c2[0] = 1'b1;

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_main
         assign b_sel[gi*BCD_DIGIT_W +: BCD_DIGIT_W] = is_sub ?
            (4'd9 - bcd2[gi*BCD_DIGIT_W +: BCD_DIGIT_W]) :
            bcd2[gi*BCD_DIGIT_W +: BCD_DIGIT_W];
         bcd_digit_adder u_add (
            .a    (bcd1[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .b    (b_sel[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cin  (c1[gi]),
            .sum  (raw[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cout (c1[gi+1])
         );
      end

      // Ten's complement of the raw difference gives the magnitude when A < B.
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_comp
         assign raw_comp[gi*BCD_DIGIT_W +: BCD_DIGIT_W] =
            4'd9 - raw[gi*BCD_DIGIT_W +: BCD_DIGIT_W];
         bcd_digit_adder u_cmp (
            .a    (4'd0),
            .b    (raw_comp[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cin  (c2[gi]),
            .sum  (mag[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cout (c2[gi+1])
         );
      end
   endgenerate

   assign cmp_carry_unused = c2[NUM_DIGITS];

`ifdef BCD_ALU_DIGIT_CHECK_EN
   logic [2*NUM_DIGITS-1:0] nib_bad;
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_check
         assign nib_bad[2*gi]   = (bcd1[gi*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9);
         assign nib_bad[2*gi+1] = (bcd2[gi*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9);
      end
   endgenerate
`endif

   always_comb begin
      res_next  = raw;
      flag_next = c1[NUM_DIGITS];
      if (is_sub) begin
         res_next  = c1[NUM_DIGITS] ? raw : mag;
         flag_next = ~c1[NUM_DIGITS];
      end
`ifdef BCD_ALU_DIGIT_CHECK_EN
      if (|nib_bad) begin
         res_next  = '0;
         flag_next = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         bcd_out_reg <= '0;
         flag_reg    <= 1'b0;
      end else if (is_add || is_sub) begin
         bcd_out_reg <= res_next;
         flag_reg    <= flag_next;
      end
   end

   assign bcd_out        = bcd_out_reg;
   assign special_signal = flag_reg;

endmodule

// File: tb/tb_bcd_alu.sv
// Scoreboard bench for bcd_alu: driver pushes model results, monitor pops and compares.
module tb_bcd_alu;

   logic        clk = 1'b0;
   logic        clear = 1'b1;
   logic [15:0] bcd1 = '0;
   logic [15:0] bcd2 = '0;
   logic [1:0]  op_selected = 2'b00;
   logic [15:0] bcd_out;
   logic        special_signal;

   int checks = 0;
   int passed = 0;

   typedef struct {
      logic [15:0] out;
      logic        flag;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   logic [15:0] m_out = '0;
   logic        m_flag = 1'b0;

   always #5 clk = ~clk;

   bcd_alu #(.NUM_DIGITS(4)) dut (
      .clk            (clk),
      .clear          (clear),
      .bcd1           (bcd1),
      .bcd2           (bcd2),
      .op_selected    (op_selected),
      .bcd_out        (bcd_out),
      .special_signal (special_signal)
   );

   function automatic int to_int(input logic [15:0] v);
      int r = 0;
      for (int d = 3; d >= 0; d--) r = r*10 + int'(v[d*4 +: 4]);
      return r;
   endfunction

   function automatic logic [15:0] to_bcd(input int n);
      logic [15:0] r = '0;
      int t = n;
      for (int d = 0; d < 4; d++) begin
         r[d*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic bit has_bad(input logic [15:0] v);
      for (int d = 0; d < 4; d++) if (v[d*4 +: 4] > 4'd9) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [15:0] rand_bcd();
      logic [15:0] r;
      for (int d = 0; d < 4; d++) r[d*4 +: 4] = 4'($urandom_range(0, 9));
      return r;
   endfunction

   // Drive one cycle of inputs and record the value expected after the next edge.
   task automatic apply(input logic c, input logic [1:0] op,
                        input logic [15:0] a, input logic [15:0] b, input string name);
      exp_t e;
      int ia, ib;
      @(negedge clk);
      clear = c; op_selected = op; bcd1 = a; bcd2 = b;
      ia = to_int(a); ib = to_int(b);
      if (c) begin
         m_out = '0; m_flag = 1'b0;
      end else if (op == 2'b01 || op == 2'b10) begin
`ifdef BCD_ALU_DIGIT_CHECK_EN
         if (has_bad(a) || has_bad(b)) begin
            m_out = '0; m_flag = 1'b1;
         end else
`endif
         if (op == 2'b01) begin
            m_out = to_bcd((ia + ib) % 10000); m_flag = (ia + ib) > 9999;
         end else if (ia >= ib) begin
            m_out = to_bcd(ia - ib); m_flag = 1'b0;
         end else begin
            m_out = to_bcd(ib - ia); m_flag = 1'b1;
         end
      end
      e.out = m_out; e.flag = m_flag; e.name = name;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bcd_out === e.out && special_signal === e.flag) begin
               passed++;
               $display("ok   %s: out=%h flag=%b", e.name, bcd_out, special_signal);
            end else begin
               $display("FAIL %s: got out=%h flag=%b, expected out=%h flag=%b",
                        e.name, bcd_out, special_signal, e.out, e.flag);
            end
         end
      end
   end

   initial begin : driver
      logic [1:0]  op;
      logic [15:0] a, b;
      int budget;
      apply(1'b1, 2'b00, 16'h0000, 16'h0000, "reset");
      apply(1'b0, 2'b01, 16'h4321, 16'h1234, "pre_add");
      apply(1'b1, 2'b01, 16'h1111, 16'h2222, "clear_over_add");
      apply(1'b0, 2'b01, 16'h1200, 16'h2300, "add_basic");
      apply(1'b0, 2'b10, 16'h4500, 16'h2300, "sub_pos");
      apply(1'b0, 2'b10, 16'h1500, 16'h2500, "sub_neg");
      apply(1'b0, 2'b10, 16'h0042, 16'h0042, "sub_equal");
      apply(1'b0, 2'b01, 16'h9999, 16'h0001, "add_overflow");
      apply(1'b0, 2'b01, 16'h0558, 16'h0447, "add_ripple");
      apply(1'b0, 2'b00, 16'h9876, 16'h0123, "hold_00");
      apply(1'b0, 2'b11, 16'h3333, 16'h7777, "hold_11");
      apply(1'b0, 2'b10, 16'h0000, 16'h9999, "sub_max_neg");
      apply(1'b0, 2'b11, 16'h1000, 16'h0001, "hold_after_neg");
`ifdef BCD_ALU_DIGIT_CHECK_EN
      apply(1'b0, 2'b01, 16'h00A1, 16'h0000, "bad_digit_add");
      apply(1'b0, 2'b00, 16'h00A1, 16'h0000, "bad_digit_hold");
      apply(1'b0, 2'b10, 16'h0012, 16'hF000, "bad_digit_sub");
`endif
      for (int i = 0; i < 200; i++) begin
         op = 2'($urandom_range(0, 3));
         a = rand_bcd();
         b = rand_bcd();
         apply(($urandom_range(0, 19) == 0), op, a, b, "random");
      end
      budget = 0;
      while (exp_q.size() > 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      #2;
      if (exp_q.size() > 0) begin
         checks++;
         $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
